// File: rtl/bp_be_clint_responder.sv
// Core-local interruptor: mtime, per-hart mtimecmp and msoftint behind a
// single-outstanding MMIO request/response port, plus timer/software IRQs.
module bp_be_clint_responder #(
    parameter int num_core_p    = 2,
    parameter int paddr_width_p = 39,
    parameter int itag_width_p  = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     mtime_tick_i,

    input  logic                     mmio_v_i,
    output logic                     mmio_ready_o,
    input  logic                     mmio_w_i,
    input  logic [paddr_width_p-1:0] mmio_addr_i,
    input  logic [63:0]              mmio_data_i,
    input  logic [itag_width_p-1:0]  mmio_tag_i,

    output logic                     resp_v_o,
    input  logic                     resp_yumi_i,
    output logic [63:0]              resp_data_o,
    output logic [itag_width_p-1:0]  resp_tag_o,
    output logic                     resp_err_o,

    output logic [num_core_p-1:0]    timer_irq_o,
    output logic [num_core_p-1:0]    soft_irq_o
);

    localparam logic [paddr_width_p-1:0] mtime_addr_lp = paddr_width_p'(39'h6f_ffff_0000);
    localparam logic [paddr_width_p-1:0] cmp_base_lp   = paddr_width_p'(39'h6f_ffff_0100);
    localparam logic [paddr_width_p-1:0] soft_base_lp  = paddr_width_p'(39'h6f_ffff_0200);
    localparam logic [5:0]               num_core_lp   = 6'(num_core_p);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    state_e                  state_reg;
    logic                    ready_reg;
    logic                    resp_v_reg;
    logic                    resp_err_reg;
    logic [63:0]             resp_data_reg;
    logic [itag_width_p-1:0] resp_tag_reg;

    logic [63:0]             mtime_reg;
    logic [63:0]             mtime_next;
    logic [63:0]             mtimecmp [num_core_p];
    logic [num_core_p-1:0]   msoftint;

    logic [4:0]              hart_idx;
    logic                    hart_ok;
    logic                    aligned;
    logic                    mtime_hit;
    logic                    cmp_hit;
    logic                    soft_hit;
    logic                    addr_err;
    logic                    accept;
    logic                    wr_ok;
    logic                    mtime_we;
    logic [63:0]             rdata;

    // Address decode: each region is one 256-byte page, 8 bytes per hart.
    assign hart_idx  = mmio_addr_i[7:3];
    assign hart_ok   = ({1'b0, hart_idx} < num_core_lp);
    assign aligned   = (mmio_addr_i[2:0] == 3'b000);
    assign mtime_hit = (mmio_addr_i[paddr_width_p-1:3] == mtime_addr_lp[paddr_width_p-1:3]);
    assign cmp_hit   = (mmio_addr_i[paddr_width_p-1:8] == cmp_base_lp[paddr_width_p-1:8]) && hart_ok;
    assign soft_hit  = (mmio_addr_i[paddr_width_p-1:8] == soft_base_lp[paddr_width_p-1:8]) && hart_ok;
    assign addr_err  = !aligned || !(mtime_hit || cmp_hit || soft_hit);

    // Gating ready with reset keeps requests from being seen as accepted while held in reset.
    assign mmio_ready_o = ready_reg && reset_n_i;
    assign accept       = mmio_v_i && ready_reg && reset_n_i;
    assign wr_ok        = accept && mmio_w_i && !addr_err;
    assign mtime_we     = wr_ok && mtime_hit;

    always_comb begin
        rdata = '0;
        if (mtime_hit) begin
            rdata = mtime_reg;
        end
        for (int h = 0; h < num_core_p; h++) begin
            if (cmp_hit && (hart_idx == 5'(h))) begin
                rdata = mtimecmp[h];
            end
            if (soft_hit && (hart_idx == 5'(h))) begin
                rdata = {63'b0, msoftint[h]};
            end
        end
    end

    // A same-cycle store overrides the tick rather than being incremented.
    always_comb begin
        mtime_next = mtime_reg;
        if (mtime_we) begin
            mtime_next = mmio_data_i;
        end else if (mtime_tick_i) begin
            mtime_next = mtime_reg + 64'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < num_core_p; gi++) begin : g_hart
            logic        sel;
            logic [63:0] cmp_reg;
            logic        soft_reg;
            logic        timer_irq_reg;

            assign sel          = (hart_idx == 5'(gi));
            assign mtimecmp[gi] = cmp_reg;
            assign msoftint[gi] = soft_reg;
            assign soft_irq_o[gi]  = soft_reg;
            assign timer_irq_o[gi] = timer_irq_reg;

            always_ff @(posedge clk_i) begin
                if (!reset_n_i) begin
                    cmp_reg       <= '1;
                    soft_reg      <= 1'b0;
                    timer_irq_reg <= 1'b0;
                end else begin
                    if (wr_ok && cmp_hit && sel) begin
                        cmp_reg <= mmio_data_i;
                    end
                    if (wr_ok && soft_hit && sel) begin
                        soft_reg <= mmio_data_i[0];
                    end
                    timer_irq_reg <= (mtime_reg >= cmp_reg);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_reg     <= IDLE;
            ready_reg     <= 1'b1;
            resp_v_reg    <= 1'b0;
            resp_err_reg  <= 1'b0;
            resp_data_reg <= '0;
            resp_tag_reg  <= '0;
            mtime_reg     <= '0;
        end else begin
            mtime_reg <= mtime_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg     <= RESP;
                        ready_reg     <= 1'b0;
                        resp_v_reg    <= 1'b1;
                        resp_tag_reg  <= mmio_tag_i;
                        resp_err_reg  <= addr_err;
                        resp_data_reg <= (mmio_w_i || addr_err) ? 64'd0 : rdata;
                    end
                end
                RESP: begin
                    if (resp_yumi_i) begin
                        state_reg  <= IDLE;
                        ready_reg  <= 1'b1;
                        resp_v_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    ready_reg  <= 1'b1;
                    resp_v_reg <= 1'b0;
                end
            endcase
        end
    end

    assign resp_v_o    = resp_v_reg;
    assign resp_data_o = resp_data_reg;
    assign resp_tag_o  = resp_tag_reg;
    assign resp_err_o  = resp_err_reg;

endmodule

// File: tb/tb_bp_be_clint_responder.sv
// Directed bench for bp_be_clint_responder: stimulus pushes expected responses,
// a monitor pops and compares them on each response handshake.
module tb_bp_be_clint_responder;

    logic        clk;
    logic        reset_n;
    logic        mtime_tick;
    logic        mmio_v;
    logic        mmio_ready;
    logic        mmio_w;
    logic [38:0] mmio_addr;
    logic [63:0] mmio_data;
    logic [7:0]  mmio_tag;
    logic        resp_v;
    logic        resp_yumi;
    logic [63:0] resp_data;
    logic [7:0]  resp_tag;
    logic        resp_err;
    logic [1:0]  timer_irq;
    logic [1:0]  soft_irq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  tag;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    bp_be_clint_responder #(
        .num_core_p   (2),
        .paddr_width_p(39),
        .itag_width_p (8)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .mtime_tick_i(mtime_tick),
        .mmio_v_i    (mmio_v),
        .mmio_ready_o(mmio_ready),
        .mmio_w_i    (mmio_w),
        .mmio_addr_i (mmio_addr),
        .mmio_data_i (mmio_data),
        .mmio_tag_i  (mmio_tag),
        .resp_v_o    (resp_v),
        .resp_yumi_i (resp_yumi),
        .resp_data_o (resp_data),
        .resp_tag_o  (resp_tag),
        .resp_err_o  (resp_err),
        .timer_irq_o (timer_irq),
        .soft_irq_o  (soft_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request/response transaction; the response is held one extra cycle before yumi.
    task automatic req(input logic w, input logic [38:0] addr, input logic [63:0] wdata,
                       input logic [7:0] tag, input logic [63:0] exp_data, input logic exp_err,
                       input logic tick);
        exp_t e;
        int   n;
        e.data = exp_data;
        e.tag  = tag;
        e.err  = exp_err;
        exp_q.push_back(e);
        mmio_v     = 1'b1;
        mmio_w     = w;
        mmio_addr  = addr;
        mmio_data  = wdata;
        mmio_tag   = tag;
        mtime_tick = tick;
        n = 0;
        @(negedge clk);
        while (!mmio_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!mmio_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=%b expected 1", mmio_ready);
        end
        @(posedge clk);
        #1;
        mmio_v     = 1'b0;
        mtime_tick = 1'b0;
        chk("resp_latency", 64'(resp_v), 64'd1);
        chk("ready_in_resp", 64'(mmio_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("resp_hold", 64'(resp_v), 64'd1);
        resp_yumi = 1'b1;
        @(posedge clk);
        #1;
        resp_yumi = 1'b0;
        chk("ready_after_yumi", 64'(mmio_ready), 64'd1);
        chk("resp_v_after_yumi", 64'(resp_v), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_v && resp_yumi) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got tag %h expected no response", resp_tag);
                end else begin
                    e = exp_q.pop_front();
                    $display("resp tag=%h data=%h err=%b", resp_tag, resp_data, resp_err);
                    chk("resp_data", resp_data, e.data);
                    chk("resp_tag", 64'(resp_tag), 64'(e.tag));
                    chk("resp_err", 64'(resp_err), 64'(e.err));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset_n    = 1'b0;
        mtime_tick = 1'b1;
        mmio_v     = 1'b1;
        mmio_w     = 1'b0;
        mmio_addr  = 39'h6f_ffff_0000;
        mmio_data  = '0;
        mmio_tag   = 8'h99;
        resp_yumi  = 1'b0;

        // Reset with a request and ticks pending: nothing may be accepted.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(mmio_ready), 64'd0);
        chk("rst_resp_v", 64'(resp_v), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_tag", 64'(resp_tag), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_timer_irq", 64'(timer_irq), 64'd0);
        chk("rst_soft_irq", 64'(soft_irq), 64'd0);
        reset_n    = 1'b1;
        mmio_v     = 1'b0;
        mtime_tick = 1'b0;
        #1;
        chk("release_ready", 64'(mmio_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("release_no_resp", 64'(resp_v), 64'd0);

        // Ten ticks then an mtime read.
        mtime_tick = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        mtime_tick = 1'b0;
        req(1'b0, 39'h6f_ffff_0000, 64'd0, 8'h5a, 64'd10, 1'b0, 1'b0);
        chk("timer_irq_idle", 64'(timer_irq), 64'd0);

        // mtimecmp[1] = 20, ticks running from mtime = 10.
        req(1'b1, 39'h6f_ffff_0108, 64'd20, 8'h01, 64'd0, 1'b0, 1'b0);
        mtime_tick = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("timer_irq1_c%0d", i), 64'(timer_irq[1]), (i >= 11) ? 64'd1 : 64'd0);
            chk($sformatf("timer_irq0_c%0d", i), 64'(timer_irq[0]), 64'd0);
        end
        mtime_tick = 1'b0;
        req(1'b0, 39'h6f_ffff_0000, 64'd0, 8'h02, 64'd22, 1'b0, 1'b0);

        // msoftint[0]: only bit 0 is kept.
        req(1'b1, 39'h6f_ffff_0200, 64'h3, 8'h03, 64'd0, 1'b0, 1'b0);
        chk("soft_irq_set", 64'(soft_irq), 64'd1);
        req(1'b0, 39'h6f_ffff_0200, 64'd0, 8'h04, 64'd1, 1'b0, 1'b0);
        req(1'b0, 39'h6f_ffff_0208, 64'd0, 8'h05, 64'd0, 1'b0, 1'b0);
        req(1'b1, 39'h6f_ffff_020c, 64'h1, 8'h06, 64'd0, 1'b1, 1'b0);
        chk("soft_irq_err_store", 64'(soft_irq), 64'd1);

        // mtime wrap.
        req(1'b1, 39'h6f_ffff_0000, 64'hffff_ffff_ffff_fffe, 8'h07, 64'd0, 1'b0, 1'b0);
        mtime_tick = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mtime_tick = 1'b0;
        req(1'b0, 39'h6f_ffff_0000, 64'd0, 8'h08, 64'd0, 1'b0, 1'b0);
        req(1'b0, 39'h6f_ffff_0108, 64'd0, 8'h09, 64'd20, 1'b0, 1'b0);

        // Store to mtime in the same cycle as a tick.
        req(1'b1, 39'h6f_ffff_0000, 64'h1234_5678_9abc_def0, 8'h0a, 64'd0, 1'b0, 1'b1);
        req(1'b0, 39'h6f_ffff_0000, 64'd0, 8'h0b, 64'h1234_5678_9abc_def0, 1'b0, 1'b0);

        // Faulting accesses.
        req(1'b0, 39'h6f_ffff_0104, 64'd0, 8'h11, 64'd0, 1'b1, 1'b0);
        req(1'b0, 39'h6f_ffff_0110, 64'd0, 8'h22, 64'd0, 1'b1, 1'b0);
        req(1'b0, 39'h6f_ffff_0300, 64'd0, 8'h33, 64'd0, 1'b1, 1'b0);

        // Reset while a response is pending drops it.
        mmio_v    = 1'b1;
        mmio_w    = 1'b0;
        mmio_addr = 39'h6f_ffff_0000;
        mmio_tag  = 8'h77;
        @(posedge clk);
        #1;
        mmio_v = 1'b0;
        chk("pre_rst_resp_v", 64'(resp_v), 64'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_resp_v", 64'(resp_v), 64'd0);
        chk("rst_in_resp_ready", 64'(mmio_ready), 64'd0);
        chk("rst_in_resp_tag", 64'(resp_tag), 64'd0);
        chk("rst_in_resp_soft", 64'(soft_irq), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(mmio_ready), 64'd1);
        chk("post_rst_resp_v", 64'(resp_v), 64'd0);
        chk("post_rst_timer", 64'(timer_irq), 64'd0);
        req(1'b0, 39'h6f_ffff_0000, 64'd0, 8'h0c, 64'd0, 1'b0, 1'b0);
        req(1'b0, 39'h6f_ffff_0100, 64'd0, 8'h0d, 64'hffff_ffff_ffff_ffff, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
